// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// piso_serializer -- parallel-in serial-out shifter, valid/ready load, enable-paced
// Revision: 1.0
// ============================================================================
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             w_shifting;
  logic             w_at_last;
  logic             w_load;

  assign w_shifting = (r_state == S_SHIFT);
  assign w_at_last  = w_shifting && (r_cnt == C_LAST);
  assign in_ready   = (r_state == S_IDLE) || (w_at_last && shift_en);
  assign w_load     = in_valid && in_ready;

  // The outgoing bit always sits at the register's exit end, so no variable index is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_load) begin
      r_state <= S_SHIFT;
      r_cnt   <= '0;
      r_shreg <= in_data;
    end else if (w_shifting && shift_en) begin
      if (w_at_last) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_shreg <= '0;
      end else begin
        r_cnt   <= r_cnt + C_ONE;
        r_shreg <= LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
      end
    end
  end

  assign ser_valid = w_shifting;
  assign busy      = w_shifting;
  assign ser_first = w_shifting && (r_cnt == '0);
  assign ser_last  = w_at_last;
  assign ser_out   = w_shifting ? (LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1]) : IDLE_LEVEL;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// tb_piso_serializer -- LSB-first/idle-0 and MSB-first/idle-1 instances vs a word-level model
// Revision: 1.0
// ============================================================================
module tb_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         shift_en = 1'b0;
  logic [W-1:0] in_data = '0;

  logic ready_a, out_a, valid_a, first_a, last_a, busy_a;
  logic ready_b, out_b, valid_b, first_b, last_b, busy_b;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_a), .in_data(in_data),
    .shift_en(shift_en), .ser_out(out_a), .ser_valid(valid_a), .ser_first(first_a),
    .ser_last(last_a), .busy(busy_a));

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_b), .in_data(in_data),
    .shift_en(shift_en), .ser_out(out_b), .ser_valid(valid_b), .ser_first(first_b),
    .ser_last(last_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Word-level model: the word being sent and which bit position of it is on the line.
  logic         m_act  = 1'b0;
  int           m_pos  = 0;
  logic [W-1:0] m_word = '0;
  int           words  = 0;
  int           bits   = 0;

  always @(posedge clk) begin
    logic rdy;
    rdy = !m_act || (m_pos == W - 1 && shift_en);
    if (!rst_n) begin
      m_act = 1'b0; m_pos = 0; m_word = '0; words = 0; bits = 0;
    end else begin
      if (valid_a && shift_en) bits++;
      if (rdy && in_valid) words++;
      if (!m_act) begin
        if (in_valid) begin m_act = 1'b1; m_word = in_data; m_pos = 0; end
      end else if (shift_en) begin
        if (m_pos < W - 1)  m_pos++;
        else if (in_valid) begin m_word = in_data; m_pos = 0; end
        else               m_act = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic e_rdy, e_first, e_last;
    if (chk_en) begin
      e_rdy   = !m_act || (m_pos == W - 1 && shift_en);
      e_first = m_act && m_pos == 0;
      e_last  = m_act && m_pos == W - 1;
      check("cycle_lsb", {10'd0, ready_a, valid_a, first_a, last_a, busy_a, out_a},
            {10'd0, e_rdy, m_act, e_first, e_last, m_act, m_act ? m_word[m_pos] : 1'b0});
      check("cycle_msb", {10'd0, ready_b, valid_b, first_b, last_b, busy_b, out_b},
            {10'd0, e_rdy, m_act, e_first, e_last, m_act, m_act ? m_word[W-1-m_pos] : 1'b1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    shift_en = 1'b1;
    repeat (W + 2) tick();
  endtask

  // Loads one word with shift_en held high and records the eight bit cycles.
  task automatic run_word(input logic [W-1:0] d, output logic [W-1:0] ca, output logic [W-1:0] cb,
                          output logic [W-1:0] cf, output logic [W-1:0] cl);
    shift_en = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      ca[i] = out_a; cb[i] = out_b; cf[i] = first_a; cl[i] = last_a;
      tick();
    end
  endtask

  initial begin
    logic [W-1:0] ca, cb, cf, cl, cap;
    logic [15:0]  v16, o16, r16, f16;
    int           cnt;
    logic         acc;

    // Reset with in_valid and shift_en high: nothing may load.
    rst_n = 1'b0; in_valid = 1'b1; shift_en = 1'b1; in_data = 8'h5A;
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_lsb", {12'd0, ready_a, valid_a, busy_a, out_a}, 16'h0008);
      check("rst_msb", {12'd0, ready_b, valid_b, busy_b, out_b}, 16'h0009);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    settle();

    run_word(8'hA5, ca, cb, cf, cl);
    check("a5_lsb_bits", {8'd0, ca}, 16'h00A5);
    check("a5_msb_bits", {8'd0, cb}, 16'h00A5);
    check("a5_first", {8'd0, cf}, 16'h0001);
    check("a5_last", {8'd0, cl}, 16'h0080);
    @(negedge clk);
    check("a5_idle_after", {14'd0, valid_a, valid_b}, 16'h0000);
    settle();

    // Paced: one shift strobe every fourth cycle.
    shift_en = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    cnt = 0; cap = '0;
    for (int k = 0; k < 40; k++) begin
      shift_en = (k % 4 == 3);
      @(negedge clk);
      if (valid_a) cnt++;
      if (k % 4 == 0 && k < 32) cap[k/4] = out_a;
      tick();
    end
    check("paced_valid_cycles", 16'(cnt), 16'd32);
    check("paced_bits", {8'd0, cap}, 16'h003C);
    settle();

    // Back-to-back FF then 00.
    shift_en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v16[i] = valid_a; o16[i] = out_a; r16[i] = ready_a; f16[i] = first_a;
      acc = in_valid && ready_a;
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("b2b_valid", v16, 16'hFFFF);
    check("b2b_bits", o16, 16'h00FF);
    check("b2b_ready", r16, 16'h8080);
    check("b2b_first", f16, 16'h0101);
    settle();

    // Reset in the middle of a word.
    shift_en = 1'b1; in_valid = 1'b1; in_data = 8'hF0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", {14'd0, valid_a, valid_b}, 16'h0000);
    run_word(8'h81, ca, cb, cf, cl);
    check("after_rst_lsb", {8'd0, ca}, 16'h0081);
    check("after_rst_msb", {8'd0, cb}, 16'h0081);
    settle();

    // Random traffic; the source holds a pending word stable until it is taken.
    in_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = in_valid && ready_a;
      tick();
      shift_en = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = W'($urandom);
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    shift_en = 1'b0;
    tick();
    tick();
    settle();
    check("bit_conservation", 16'(bits), 16'(words * W));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shift register with a valid/ready load handshake and an enable-paced bit clock.
- Transmit-side counterpart to the capture flops and serial-in registers in the building-block library. It converts a WIDTH-bit word into a bit stream, one bit per enabled cycle.
- Intended to feed serial links, LED/SPI-style chains and bench stimulus. It sustains back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..64.
- LSB_FIRST, 1, 1 = bit 0 is shifted out first; 0 = bit WIDTH-1 is shifted out first.
- IDLE_LEVEL, 1'b0, value driven on ser_out while no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  in_data holds a word to load.
- in_ready  output  1  serializer accepts a word this cycle.
- in_data  input  WIDTH  parallel word; sampled only when in_valid && in_ready.
- shift_en  input  1  bit-rate strobe; advances the stream by one bit when high.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a data bit.
- ser_first  output  1  ser_out is the first bit of a word.
- ser_last  output  1  ser_out is the last bit of a word.
- busy  output  1  a word is loaded and being shifted; same as ser_valid.

Behaviour:
- Reset is synchronous, active-low and takes priority over all other inputs. With rst_n low at a rising edge:
  - state becomes IDLE and the bit counter becomes 0;
  - the shift register is cleared;
  - after that edge: in_ready=1, ser_valid=ser_first=ser_last=busy=0, ser_out=IDLE_LEVEL.
- Reset mid-word: the partial word is discarded, no further bits are emitted, and there is no flush.
- FSM states: IDLE and SHIFT. The bit counter is $clog2(WIDTH) bits wide and counts 0..WIDTH-1.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: load in_data into the shift register, clear the counter, go to SHIFT.
  - Latency: the first bit appears on ser_out in the cycle after acceptance, regardless of shift_en.
- SHIFT:
  - ser_valid=1.
  - ser_out = bit[counter] when LSB_FIRST=1, else bit[WIDTH-1-counter]. It is registered or muxed directly from the shift register; there is no combinational path from in_data.
  - shift_en=0: hold ser_out, the counter and all flags. Stall length is unbounded.
  - shift_en=1 and counter<WIDTH-1: increment the counter, moving to the next bit.
  - shift_en=1 and counter==WIDTH-1, with in_valid=1: load the new word, clear the counter, stay in SHIFT. The first bit of the new word follows the last bit of the old one with no gap.
  - shift_en=1 and counter==WIDTH-1, with in_valid=0: go to IDLE; ser_out returns to IDLE_LEVEL next cycle.
- in_ready (combinational) = (state==IDLE) || (state==SHIFT && counter==WIDTH-1 && shift_en).
  - in_ready must never depend combinationally on in_data.
  - A word presented with in_valid=1 and in_ready=0 stays pending and must be held stable by the source.
- Flags:
  - ser_first = SHIFT && counter==0.
  - ser_last = SHIFT && counter==WIDTH-1.
  - Both are asserted for the full duration of that bit, including stalls.
- shift_en while IDLE has no effect.
- in_valid together with shift_en in IDLE: the word is loaded; the first bit still lasts until the next shift_en after it appears.
- No data is dropped or duplicated. Exactly WIDTH ser_valid bit-periods are produced per accepted word.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with in_valid=1 and shift_en=1 -> in_ready=1, ser_valid=0, ser_out=IDLE_LEVEL; no load occurs.
- Single word, WIDTH=8, LSB_FIRST=1, in_data=8'hA5, shift_en=1 constantly:
  - ser_out = 1,0,1,0,0,1,0,1 over 8 consecutive cycles;
  - ser_first asserted on bit 0 only; ser_last asserted on bit 7 only;
  - IDLE in the following cycle.
- MSB-first, LSB_FIRST=0, in_data=8'hA5 -> ser_out = 1,0,1,0,0,1,0,1, matching 8'b10100101 read from MSB down.
- Paced output: shift_en high every 4th cycle, in_data=8'h3C -> each bit held exactly 4 cycles; flags stable throughout each bit; 32 ser_valid cycles in total.
- Back-to-back: 8'hFF then 8'h00 with in_valid held high -> 16 contiguous ser_valid cycles (eight 1s, then eight 0s); in_ready pulses only on the last-bit cycle; ser_first on cycles 0 and 8.
- Reset mid-word: load 8'hF0 and assert rst_n=0 after bit 3 -> ser_valid=0 next cycle; a subsequent load of 8'h81 emits 1,0,0,0,0,0,0,1 cleanly.
